mdu_iter: RTL

- Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Generalised successor of the single-cycle integer ALU, adding configurable data width, a configurable number of bits retired per cycle, and a valid/ready handshake.
- Sits beside the ALU in the execute stage; the pipeline stalls on in_ready / out_valid.

---
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_iter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage and the
// iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and
// restoring divide on magnitudes, STEP bits per cycle, sign fix-up last.
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  mdu_iter_if.slave bus
);
  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int W  = XLEN + STEP;
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t state, state_d;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   quo;
  logic [XLEN:0]     rem;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result_q;
  logic              neg_res;
  logic              neg_rem;
  logic [CW-1:0]     cnt;

  logic            accept, sa, sb;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic [XLEN-1:0] special_val;

  always_comb begin
    accept = bus.in_valid && state == IDLE && !flush;
    sa = bus.a[XLEN-1] &&
      (bus.op inside {3'd1, 3'd2, 3'd4, 3'd6});
    sb = bus.b[XLEN-1] &&
      (bus.op inside {3'd1, 3'd4, 3'd6});
    mag_a_in = sa ? -bus.a : bus.a;
    mag_b_in = sb ? -bus.b : bus.b;
    b_zero = bus.b == '0;
    ovf = !bus.op[0] && bus.a == MIN && (&bus.b);
    special = bus.op[2] && (b_zero || ovf);
    // op[1] separates REM* from DIV*
    if (b_zero)
      special_val = bus.op[1] ? bus.a : '1;
    else
      special_val = bus.op[1] ? '0 : bus.a;
  end

  logic [W-1:0]      pp, hi;
  logic [2*XLEN-1:0] prod_nx;
  logic [XLEN:0]     r_nx;
  logic [XLEN-1:0]   q_nx;

  always_comb begin
    pp = W'(mag_b) * W'(prod[STEP-1:0]);
    hi = W'(prod[2*XLEN-1:XLEN]) + pp;
    prod_nx = {hi, prod[XLEN-1:STEP]};
    r_nx = rem;
    q_nx = quo;
    for (int i = 0; i < STEP; i++) begin
      r_nx = {r_nx[XLEN-1:0], q_nx[XLEN-1]};
      q_nx = {q_nx[XLEN-2:0], 1'b0};
      if (r_nx >= {1'b0, mag_b}) begin
        r_nx = r_nx - {1'b0, mag_b};
        q_nx[0] = 1'b1;
      end
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_val;

  always_comb begin
    prod_s = neg_res ? -prod : prod;
    quo_s = neg_res ? -quo : quo;
    rem_s = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    fix_val = '0;
    unique case (1'b1)
      op_q == 3'd0:
        fix_val = prod_s[XLEN-1:0];
      !op_q[2] && op_q != 3'd0:
        fix_val = prod_s[2*XLEN-1:XLEN];
      op_q[2:1] == 2'b10:
        fix_val = quo_s;
      op_q[2:1] == 2'b11:
        fix_val = rem_s;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept)
        state_d = special ? DONE : CALC;
      CALC: if (cnt == CW'(1))
        state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready)
        state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      op_q     <= '0;
      mag_b    <= '0;
      quo      <= '0;
      rem      <= '0;
      prod     <= '0;
      result_q <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q    <= bus.op;
          mag_b   <= mag_b_in;
          quo     <= mag_a_in;
          rem     <= '0;
          prod    <= {{XLEN{1'b0}}, mag_a_in};
          neg_res <= sa ^ sb;
          neg_rem <= sa;
          cnt     <= special ? '0 : CW'(N);
          if (special)
            result_q <= special_val;
        end
        CALC: begin
          cnt  <= cnt - CW'(1);
          prod <= prod_nx;
          rem  <= r_nx;
          quo  <= q_nx;
        end
        FIX:  result_q <= fix_val;
        DONE: if (bus.out_ready)
          result_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.result    = result_q;
endmodule
